// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 4-requester round-robin arbiter driving a shared 4:1 data mux.
// A grant is held for a whole burst. The burst ends on Last, or on a forced
// release after MAX_BURST beats. Priority then rotates past the requester that
// was just served.
// Ports:
//   Clock_In, Reset_In                  clock, async active-high reset
//   Enable_In                           permits new grants
//   Req_Valid_In/Req_Last_In/Req_Data_In per-requester beat interface
//   Req_Ready_Out                       per-requester accept
//   Out_Valid_Out/Out_Data_Out/Out_Last_Out, Out_Ready_In  downstream beat
//   Select_Out, Grant_Out, Busy_Out, Timeout_Out            status
module mux_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                      Clock_In,
  input  logic                      Reset_In,
  input  logic                      Enable_In,
  input  logic [3:0]                Req_Valid_In,
  input  logic [3:0]                Req_Last_In,
  input  logic [4*DATA_WIDTH-1:0]   Req_Data_In,
  output logic [3:0]                Req_Ready_Out,
  output logic                      Out_Valid_Out,
  output logic [DATA_WIDTH-1:0]     Out_Data_Out,
  output logic                      Out_Last_Out,
  input  logic                      Out_Ready_In,
  output logic [1:0]                Select_Out,
  output logic [3:0]                Grant_Out,
  output logic                      Busy_Out,
  output logic                      Timeout_Out
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic                  locked;
  logic                  beat;
  logic                  pick_found;
  logic [1:0]            pick_idx;
  logic [DATA_WIDTH-1:0] req_data [4];

  // Unpack the flat data bus into per-requester words
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_data[i] = Req_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search starting at the priority pointer
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!pick_found && Req_Valid_In[ptr_q + 2'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr_q + 2'(k);
      end
    end
  end

  // Combinational pass-through of the granted requester; all zero while idle
  always_comb begin
    locked        = (state_q == ST_LOCKED);
    Out_Valid_Out = locked & Req_Valid_In[sel_q];
    Out_Data_Out  = locked ? req_data[sel_q] : '0;
    Out_Last_Out  = locked & Req_Last_In[sel_q];
    Req_Ready_Out = locked ? (4'(Out_Ready_In) << sel_q) : 4'b0000;
    beat          = Out_Valid_Out & Out_Ready_In;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Enable_In && pick_found) begin
          state_d = ST_LOCKED;
          sel_d   = pick_idx;
          grant_d = 4'b0001 << pick_idx;
          cnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        // Stalled cycles are not beats, so they never advance the count
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (Req_Last_In[sel_q] || (cnt_q == CNT_LAST)) begin
            state_d   = ST_IDLE;
            ptr_d     = sel_q + 2'd1;
            grant_d   = 4'b0000;
            // Pulse only for a count-forced release; Last wins a tie
            timeout_d = ~Req_Last_In[sel_q];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // State registers
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      grant_q   <= 4'b0000;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Select_Out  = sel_q;
  assign Grant_Out   = grant_q;
  assign Busy_Out    = (state_q == ST_LOCKED);
  assign Timeout_Out = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios plus randomized producers,
// checked by a cycle-level reference model feeding a scoreboard queue.
module tb_mux_rr_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic                 Clock_In = 1'b0;
  logic                 Reset_In = 1'b1;
  logic                 en = 1'b0;
  logic [3:0]           vld = 4'b0;
  logic [3:0]           lst = 4'b0;
  logic [3:0][DW-1:0]   dat = '0;
  logic                 ordy = 1'b0;

  logic [3:0]           Req_Ready_Out;
  logic                 Out_Valid_Out;
  logic [DW-1:0]        Out_Data_Out;
  logic                 Out_Last_Out;
  logic [1:0]           Select_Out;
  logic [3:0]           Grant_Out;
  logic                 Busy_Out;
  logic                 Timeout_Out;

  mux_rr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .Clock_In      (Clock_In),
    .Reset_In      (Reset_In),
    .Enable_In     (en),
    .Req_Valid_In  (vld),
    .Req_Last_In   (lst),
    .Req_Data_In   (dat),
    .Req_Ready_Out (Req_Ready_Out),
    .Out_Valid_Out (Out_Valid_Out),
    .Out_Data_Out  (Out_Data_Out),
    .Out_Last_Out  (Out_Last_Out),
    .Out_Ready_In  (ordy),
    .Select_Out    (Select_Out),
    .Grant_Out     (Grant_Out),
    .Busy_Out      (Busy_Out),
    .Timeout_Out   (Timeout_Out)
  );

  always #5 Clock_In = ~Clock_In;

  typedef struct {
    logic [3:0]    grant;
    logic [1:0]    sel;
    logic          chk_sel;
    logic          busy;
    logic          to;
    logic          ovalid;
    logic [DW-1:0] odata;
    logic          olast;
    logic [3:0]    ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model: owner is the granted requester, or -1 when nobody holds the mux
  int   owner = -1;
  int   prio = 0;
  int   beats = 0;
  bit   pend_to = 1'b0;
  logic [3:0] acc = 4'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  // Predict this cycle's outputs from current inputs, queue them, advance the model
  task automatic cycle();
    exp_t e;
    int s;
    e.grant = 4'b0; e.sel = 2'd0; e.chk_sel = 1'b0; e.busy = 1'b0;
    e.ovalid = 1'b0; e.odata = '0; e.olast = 1'b0; e.ready = 4'b0;
    e.to = pend_to;
    pend_to = 1'b0;
    acc = 4'b0;
    if (owner < 0) begin
      if (en && vld != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (owner < 0 && vld[(prio + k) % 4]) begin
            owner = (prio + k) % 4;
            beats = 0;
          end
        end
      end
    end else begin
      s = owner;
      e.grant   = 4'(1 << s);
      e.sel     = 2'(s);
      e.chk_sel = 1'b1;
      e.busy    = 1'b1;
      e.ovalid  = vld[s];
      e.odata   = dat[s];
      e.olast   = lst[s];
      e.ready   = ordy ? 4'(1 << s) : 4'b0;
      if (vld[s] && ordy) begin
        acc = 4'(1 << s);
        beats++;
        if (lst[s] || beats == int'(MB)) begin
          owner   = -1;
          prio    = (s + 1) % 4;
          pend_to = !lst[s];
        end
      end
    end
    exp_q.push_back(e);
    @(posedge Clock_In);
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once
  task automatic do_reset();
    Reset_In = 1'b1;
    #1;
    chk("rst_grant",   32'(Grant_Out),     32'h0);
    chk("rst_busy",    32'(Busy_Out),      32'h0);
    chk("rst_select",  32'(Select_Out),    32'h0);
    chk("rst_timeout", 32'(Timeout_Out),   32'h0);
    chk("rst_ovalid",  32'(Out_Valid_Out), 32'h0);
    chk("rst_ready",   32'(Req_Ready_Out), 32'h0);
    owner = -1; prio = 0; beats = 0; pend_to = 1'b0; acc = 4'b0;
    @(posedge Clock_In);
    #1;
    Reset_In = 1'b0;
  endtask

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge Clock_In) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("grant",   32'(Grant_Out),     32'(mon_e.grant));
      chk("busy",    32'(Busy_Out),      32'(mon_e.busy));
      chk("timeout", 32'(Timeout_Out),   32'(mon_e.to));
      chk("ovalid",  32'(Out_Valid_Out), 32'(mon_e.ovalid));
      chk("odata",   32'(Out_Data_Out),  32'(mon_e.odata));
      chk("olast",   32'(Out_Last_Out),  32'(mon_e.olast));
      chk("ready",   32'(Req_Ready_Out), 32'(mon_e.ready));
      if (mon_e.chk_sel) chk("select", 32'(Select_Out), 32'(mon_e.sel));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] arr [3];
    int idx;
    logic bp [8];

    // Reset values
    @(posedge Clock_In);
    @(posedge Clock_In);
    #1;
    chk("init_grant",  32'(Grant_Out),  32'h0);
    chk("init_busy",   32'(Busy_Out),   32'h0);
    chk("init_select", 32'(Select_Out), 32'h0);
    chk("init_ovalid", 32'(Out_Valid_Out), 32'h0);
    chk("init_odata",  32'(Out_Data_Out), 32'h0);
    Reset_In = 1'b0;

    // Single requester, three-beat burst
    arr = '{8'h11, 8'h22, 8'h33};
    idx = 0;
    en = 1'b1; ordy = 1'b1;
    for (int n = 0; n < 10 && idx < 3; n++) begin
      vld = 4'b0100;
      dat[2] = arr[idx];
      lst = (idx == 2) ? 4'b0100 : 4'b0000;
      cycle();
      if (acc[2]) idx++;
    end
    vld = 4'b0; lst = 4'b0;
    cycle(); cycle();

    // Fairness: all valid, single-beat bursts
    vld = 4'b1111; lst = 4'b1111;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 4; i++) dat[i] = DW'($urandom);
      cycle();
    end
    vld = 4'b0; cycle();

    // Backpressure on requester 1
    bp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    idx = 0;
    for (int n = 0; n < 8; n++) begin
      vld = (idx < 3) ? 4'b0010 : 4'b0000;
      dat[1] = DW'(8'h40 + idx);
      lst = (idx == 2) ? 4'b0010 : 4'b0000;
      ordy = bp[n];
      cycle();
      if (acc[1]) idx++;
    end
    ordy = 1'b1; vld = 4'b0; lst = 4'b0; cycle();

    // Timeout: requester 3 streams six beats with no Last; requester 0 joins
    idx = 0;
    for (int n = 0; n < 24 && idx < 6; n++) begin
      vld = 4'b1000;
      if (idx >= 3) begin vld[0] = 1'b1; lst[0] = 1'b1; dat[0] = 8'h5a; end
      dat[3] = DW'(8'h80 + idx);
      lst[3] = 1'b0;
      cycle();
      if (acc[3]) idx++;
      if (acc[0]) begin vld[0] = 1'b0; end
    end
    vld = 4'b0; lst = 4'b0; cycle(); cycle();

    // Enable gating, including a drop mid-burst
    en = 1'b0; vld = 4'b1111; lst = 4'b0;
    for (int n = 0; n < 4; n++) cycle();
    en = 1'b1; vld = 4'b0001; dat[0] = 8'hc1;
    cycle();
    en = 1'b0;
    cycle(); dat[0] = 8'hc2;
    cycle(); lst = 4'b0001; dat[0] = 8'hc3;
    cycle();
    vld = 4'b1111; lst = 4'b0;
    for (int n = 0; n < 3; n++) cycle();
    en = 1'b1;
    for (int n = 0; n < 3; n++) cycle();

    // Reset mid-burst after two beats, then requester 0 must win
    vld = 4'b0; cycle();
    for (int n = 0; n < 8 && owner >= 0; n++) begin ordy = 1'b1; vld = 4'b1111; lst = 4'b1111; cycle(); end
    vld = 4'b0; lst = 4'b0; cycle();
    vld = 4'b0100; lst = 4'b0; ordy = 1'b1;
    cycle(); cycle(); cycle();
    do_reset();
    vld = 4'b1111; lst = 4'b1111;
    cycle(); cycle(); cycle();

    // Randomized producers that hold a beat until it is accepted
    vld = 4'b0; lst = 4'b0; acc = 4'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!vld[i] || acc[i]) begin
          vld[i] = ($urandom % 4) != 0;
          dat[i] = DW'($urandom);
          lst[i] = ($urandom % 3) == 0;
        end
      end
      en   = ($urandom % 8) != 0;
      ordy = ($urandom % 4) != 0;
      if ($urandom % 300 == 0) begin
        do_reset();
        vld = 4'b0;
      end else begin
        cycle();
      end
    end

    vld = 4'b0; en = 1'b0;
    cycle(); cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- 4-requester round-robin arbiter and scheduler for a shared 4:1 data multiplexer.
- Each requester presents beats with a valid/ready handshake and marks the end of a burst with Last.
- The block grants one requester at a time and drives the mux select.
- It holds the grant for a whole burst (Last or MAX_BURST beats), then rotates priority.
- It sits between the per-source producers and the single shared downstream sink.

Parameters:
- DATA_WIDTH, 8, width of each requester data word.
- MAX_BURST, 16, max beats per grant before forced release; legal range >= 1.

Ports:
- Clock_In  input  1  single clock, rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Enable_In  input  1  when 0, no new grant is issued; a burst already in progress completes.
- Req_Valid_In  input  4  bit i: requester i has a beat.
- Req_Last_In  input  4  bit i: requester i's current beat is the last of its burst.
- Req_Data_In  input  4*DATA_WIDTH  requester i's data at [i*DATA_WIDTH +: DATA_WIDTH].
- Req_Ready_Out  output  4  bit i: beat from requester i is accepted this cycle.
- Out_Valid_Out  output  1  downstream beat valid.
- Out_Data_Out  output  DATA_WIDTH  downstream data.
- Out_Last_Out  output  1  downstream last marker.
- Out_Ready_In  input  1  downstream can accept a beat.
- Select_Out  output  2  mux select; index of the granted requester.
- Grant_Out  output  4  one-hot grant; all zero when idle.
- Busy_Out  output  1  1 while in LOCKED.
- Timeout_Out  output  1  one-cycle pulse when a grant is force-released at MAX_BURST.

Behaviour:
- Reset (async assert, sync-free deassert):
  - state=IDLE, Ptr=0, Grant_Out=0, Select_Out=0, Busy_Out=0.
  - Beat counter=0, Timeout_Out=0.
  - All combinational outputs are 0 while IDLE.
- States: IDLE, LOCKED. Ptr (2b) is the highest-priority index.
- IDLE:
  - If Enable_In=1 and Req_Valid_In!=0, pick the first i with a valid bit, searching Ptr, Ptr+1, ... mod 4.
  - Next edge: Select_Out=i, Grant_Out=1<<i, counter=0, state=LOCKED.
  - Arbitration latency is 1 cycle from valid to grant. No beat transfers in IDLE.
- LOCKED (s=Select_Out), pure combinational pass-through:
  - Out_Valid_Out=Req_Valid_In[s], Out_Data_Out=Req_Data_In[s], Out_Last_Out=Req_Last_In[s].
  - Req_Ready_Out[s]=Out_Ready_In; all other ready bits are 0.
  - Beat = Out_Valid_Out & Out_Ready_In. On each beat, counter increments.
- Release from LOCKED (on a beat): next edge state=IDLE, Ptr=(s+1) mod 4, Grant_Out=0.
  - Trigger is Req_Last_In[s]=1, or counter == MAX_BURST-1.
  - If the release is by count and Last=0: Timeout_Out=1 for exactly one cycle (the first IDLE cycle).
  - If Last and the count limit coincide: release, no timeout pulse.
- There is one mandatory IDLE cycle between consecutive grants (0 throughput for 1 cycle).
- Requester deasserts valid mid-burst: grant held indefinitely. Idle cycles do not count toward MAX_BURST.
- Enable_In=0 during LOCKED: no effect until release; after that, stay IDLE.
- Non-granted requesters never see ready. Their data and valid are ignored; holding them is their responsibility.
- Out_Data_Out=0 and Out_Last_Out=0 when Out_Valid_Out=0 in IDLE. In LOCKED the data passes through regardless of valid.
- Counter width is clog2(MAX_BURST+1).
- Reset asserted mid-burst: immediate return to reset values. A beat in flight is lost; no Timeout pulse.

Test Plan:
- Reset mid-burst:
  - Stimulus: Reset_In=1 asynchronously during LOCKED after 2 beats.
  - Required: Grant_Out=0, Busy_Out=0, Ptr=0 immediately.
  - Required: after release, requester 0 wins next if valid.
- Single requester:
  - Stimulus: Req_Valid_In=0100 with 3 beats of data 0x11, 0x22, 0x33, Last on the third, Out_Ready_In=1.
  - Required: Grant_Out=0100 and Select_Out=2 one cycle after valid.
  - Required: downstream sees 0x11, 0x22, 0x33 on consecutive cycles, then Grant_Out=0.
- Round-robin fairness:
  - Stimulus: all four valid continuously, 1-beat bursts (Last=1).
  - Required: grant order 0,1,2,3,0 with one IDLE cycle between each grant.
- Backpressure:
  - Stimulus: requester 1 granted, Out_Ready_In toggles 1,0,0,1.
  - Required: Req_Ready_Out[1] tracks Out_Ready_In.
  - Required: data is held by the requester and only 2 beats are counted.
- Timeout:
  - Stimulus: MAX_BURST=4, requester 3 streams 6 beats without Last.
  - Required: release after the 4th beat, Timeout_Out=1 for one cycle.
  - Required: requester 3 is re-granted only after the others, if any are valid.
- Enable gating:
  - Stimulus: Enable_In=0 with Req_Valid_In=1111.
  - Required: no grant.
  - Stimulus: drop Enable_In mid-burst.
  - Required: burst completes, then IDLE persists until Enable_In=1.
